// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeated (repeat_cnt+1) times
// with a gap of idle cycles between copies. All outputs are registered.
module seq_pattern_tx #(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] PATTERN = 5'b11011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] repeat_cnt,
    input  logic [3:0] gap,
    output logic       out,
    output logic       bit_valid,
    output logic       busy,
    output logic       done
);
    localparam int            IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] bit_idx, bit_idx_n;
    logic [3:0]    copies_left, copies_left_n;
    logic [3:0]    gap_left, gap_left_n;
    logic [3:0]    gap_lat, gap_lat_n;
    logic          out_n, bit_valid_n, busy_n, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_idx     <= '0;
            copies_left <= '0;
            gap_left    <= '0;
            gap_lat     <= '0;
            out         <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            bit_idx     <= bit_idx_n;
            copies_left <= copies_left_n;
            gap_left    <= gap_left_n;
            gap_lat     <= gap_lat_n;
            out         <= out_n;
            bit_valid   <= bit_valid_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        bit_idx_n     = bit_idx;
        copies_left_n = copies_left;
        gap_left_n    = gap_left;
        gap_lat_n     = gap_lat;
        done_n        = 1'b0;
        case (state)
            IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_n       = SEND;
                    bit_idx_n     = LAST;
                    copies_left_n = repeat_cnt;
                    gap_lat_n     = gap;
                end
            end
            SEND: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (bit_idx != '0) begin
                    bit_idx_n = bit_idx - 1'b1;
                end else if (copies_left == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    copies_left_n = copies_left - 1'b1;
                    bit_idx_n     = LAST;
                    if (gap_lat != '0) begin
                        state_n    = GAP;
                        gap_left_n = gap_lat;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gap_left == 4'd1) begin
                    state_n = SEND;
                end else begin
                    gap_left_n = gap_left - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered views of the next state
        bit_valid_n = (state_n == SEND);
        out_n       = bit_valid_n ? PATTERN[bit_idx_n] : 1'b0;
        busy_n      = (state_n != IDLE);
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: timeline model of each transmission, per-cycle compare,
// directed literal sequences, random stimulus, and an 8-bit parameter override.
module tb_seq_pattern_tx;
    localparam int          W   = 5;
    localparam logic [4:0]  PAT = 5'b11011;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [3:0] repeat_cnt = '0, gap = '0;
    logic       out, bit_valid, busy, done;
    logic       start2 = 1'b0;
    logic       out2, bit_valid2, busy2, done2;

    int n_checks = 0, n_fail = 0;
    bit chk_en = 1'b0;

    seq_pattern_tx dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .repeat_cnt(repeat_cnt), .gap(gap),
        .out(out), .bit_valid(bit_valid), .busy(busy), .done(done));

    seq_pattern_tx #(.WIDTH(8), .PATTERN(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .repeat_cnt(4'd0), .gap(4'd0),
        .out(out2), .bit_valid(bit_valid2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transmission is a timeline of length L = N*W + (N-1)*g starting one
    // cycle after the accepting edge; position t%(W+g) < W carries a pattern bit.
    bit m_active = 0;
    int m_t = 0, m_L = 0, m_g = 0;
    bit e_out = 0, e_valid = 0, e_busy = 0, e_done = 0;

    always @(posedge clk) begin
        int pos;
        e_done = 0;
        if (rst) begin
            m_active = 0;
        end else if (m_active && abort) begin
            m_active = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == m_L) begin
                m_active = 0;
                e_done   = 1;
            end
        end else if (start && !abort) begin
            m_active = 1;
            m_t      = 0;
            m_g      = gap;
            m_L      = (repeat_cnt + 1) * W + repeat_cnt * gap;
        end
        pos     = m_t % (W + m_g);
        e_busy  = m_active;
        e_valid = m_active && pos < W;
        e_out   = e_valid ? PAT[W-1-pos] : 1'b0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out", out, e_out);
            check("bit_valid", bit_valid, e_valid);
            check("busy", busy, e_busy);
            check("done", done, e_done);
        end
    end

    // Pulse start, then record n cycles from k+1. Optionally pokes a second start mid-run.
    task automatic capture(input logic [3:0] rc, input logic [3:0] g, input int n, input int poke,
                           output logic [63:0] bits, output int busy_len, output int done_at);
        bits = '0; busy_len = 0; done_at = -1;
        @(negedge clk); start = 1; repeat_cnt = rc; gap = g;
        @(negedge clk); start = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (i == poke) begin start = 1; repeat_cnt = 4'd9; gap = 4'd7; end
            if (i == poke + 1) start = 0;
            bits = {bits[62:0], out};
            busy_len += busy;
            if (done && done_at < 0) done_at = i + 1;
        end
        start = 0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy !== 1'b0 && c < 400) begin @(negedge clk); c++; end
        if (c >= 400) check({name, "_timeout"}, 1, 0);
        @(negedge clk);
    endtask

    logic [63:0] bits;
    int blen, dat;

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        check("reset_out", {out, bit_valid, busy, done}, 0);

        // Single copy, with a start poke at the 3rd bit that must be ignored
        capture(4'd0, 4'd0, 7, 2, bits, blen, dat);
        check("single_bits", bits[6:0], 7'b1101100);
        check("single_busy", blen, 5);
        check("single_done", dat, 6);

        capture(4'd2, 4'd0, 17, -1, bits, blen, dat);
        check("b2b_bits", bits[16:0], {15'b110111101111011, 2'b00});
        check("b2b_busy", blen, 15);
        check("b2b_done", dat, 16);

        capture(4'd1, 4'd3, 15, -1, bits, blen, dat);
        check("gap_bits", bits[14:0], {13'b1101100011011, 2'b00});
        check("gap_busy", blen, 13);
        check("gap_done", dat, 14);

        // Abort during the 3rd bit
        @(negedge clk); start = 1; repeat_cnt = 4'd3; gap = 4'd0;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk); abort = 1;
        @(negedge clk); abort = 0;
        check("abort_outs", {out, bit_valid, busy, done}, 0);
        @(negedge clk);
        check("abort_nodone", done, 0);

        // Start+abort together while idle: nothing starts
        start = 1; abort = 1;
        @(negedge clk); start = 0; abort = 0;
        check("start_abort_idle", busy, 0);

        // Reset in 2nd bit of copy 1 (cycle k+8 with gap 1)
        start = 1; repeat_cnt = 4'd2; gap = 4'd1;
        @(negedge clk); start = 0;
        repeat (7) @(negedge clk);
        check("pre_rst_out", {out, bit_valid, busy}, 3'b111);
        rst = 1;
        @(negedge clk); rst = 0;
        check("rst_outs", {out, bit_valid, busy, done}, 0);

        // Re-arm in the done cycle: no idle bubble
        start = 1; repeat_cnt = 4'd0; gap = 4'd0;
        @(negedge clk); start = 0;
        begin
            int c = 0;
            while (done !== 1'b1 && c < 50) begin @(negedge clk); c++; end
            check("rearm_done_seen", done, 1);
        end
        start = 1;
        @(negedge clk); start = 0;
        check("rearm_first_bit", {out, bit_valid, busy}, 3'b111);
        wait_idle("rearm");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            repeat_cnt = 4'($urandom_range(0, 15));
            gap        = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            @(negedge clk);
        end
        start = 0; abort = 0; rst = 0;
        wait_idle("random");

        // WIDTH=8, PATTERN=A5
        start2 = 1;
        @(negedge clk); start2 = 0;
        bits = '0; dat = -1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            bits = {bits[62:0], out2};
            if (done2 && dat < 0) dat = i + 1;
        end
        check("w8_bits", bits[9:0], 10'b1010010100);
        check("w8_done", dat, 9);
        check("w8_idle", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
